pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 36 +++
 rtl/pipe_skid_stage.sv | 130 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

    localparam int DEF_N_INSTR = 16;
    localparam int DEF_N_PC    = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [DEF_N_INSTR-1:0] instr;
        logic [DEF_N_PC-1:0]    pc;
    } lane_slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One beat of storage: per-lane valid mask, instructions and PCs.
// clear drops the lane mask only; the data bits keep their last value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int N_INSTR = DEF_N_INSTR,
    parameter int N_PC    = DEF_N_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     clear,
    input  logic [LANES-1:0]         d_valid,
    input  logic [LANES*N_INSTR-1:0] d_instr,
    input  logic [LANES*N_PC-1:0]    d_pc,
    output logic [LANES-1:0]         q_valid,
    output logic [LANES*N_INSTR-1:0] q_instr,
    output logic [LANES*N_PC-1:0]    q_pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= '0;
            q_instr <= '0;
            q_pc    <= '0;
        end else if (clear) begin
            q_valid <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q_instr <= d_instr;
            q_pc    <= d_pc;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: registered in_ready, outputs always from the main slot,
// skid slot absorbs the one beat accepted while downstream stalls.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int N_INSTR = DEF_N_INSTR,
    parameter int N_PC    = DEF_N_PC,
    parameter int LANES   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [LANES*N_INSTR-1:0] instruction_in,
    input  logic [LANES*N_PC-1:0]    pc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_valid,
    output logic [LANES*N_INSTR-1:0] instruction_out,
    output logic [LANES*N_PC-1:0]    pc_out,
    output logic [1:0]               occupancy,
    output logic [15:0]              bp_cycles
);

    state_t state, state_nxt;
    logic   rdy_q;
    logic   acc, beat, pop;
    logic   main_ld, skid_ld, main_from_skid;

    logic [LANES-1:0]         main_v, skid_v, main_dv;
    logic [LANES*N_INSTR-1:0] main_i, skid_i, main_di;
    logic [LANES*N_PC-1:0]    main_p, skid_p, main_dp;

    assign acc  = in_valid & rdy_q;
    // An all-lanes-invalid beat completes the handshake but is never stored.
    assign beat = acc & (|in_lane_valid);
    assign pop  = (state != EMPTY) & out_ready;

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (beat) begin
                    main_ld   = 1'b1;
                    state_nxt = HALF;
                end
                HALF: begin
                    if (beat && pop) begin
                        main_ld = 1'b1;
                    end else if (beat) begin
                        skid_ld   = 1'b1;
                        state_nxt = FULL;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = HALF;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign main_dv = main_from_skid ? skid_v : in_lane_valid;
    assign main_di = main_from_skid ? skid_i : instruction_in;
    assign main_dp = main_from_skid ? skid_p : pc_in;

    pipe_slot #(.LANES(LANES), .N_INSTR(N_INSTR), .N_PC(N_PC)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_ld),
        .clear   (flush),
        .d_valid (main_dv),
        .d_instr (main_di),
        .d_pc    (main_dp),
        .q_valid (main_v),
        .q_instr (main_i),
        .q_pc    (main_p)
    );

    pipe_slot #(.LANES(LANES), .N_INSTR(N_INSTR), .N_PC(N_PC)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_ld),
        .clear   (flush),
        .d_valid (in_lane_valid),
        .d_instr (instruction_in),
        .d_pc    (pc_in),
        .q_valid (skid_v),
        .q_instr (skid_i),
        .q_pc    (skid_p)
    );

    // rdy_q tracks (state != FULL) one register away, so out_ready never reaches in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_cycles <= '0;
        end else if (out_valid && !out_ready && bp_cycles != 16'hFFFF) begin
            bp_cycles <= bp_cycles + 16'd1;
        end
    end

    assign in_ready        = rdy_q;
    assign out_valid       = (state != EMPTY);
    assign out_lane_valid  = out_valid ? main_v : '0;
    assign instruction_out = main_i;
    assign pc_out          = main_p;
    assign occupancy       = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage (2 lanes): vector table, corner sequences, random vs queue model.
module tb_pipe_skid_stage;

    localparam int LN = 2;
    localparam int NI = 16;
    localparam int NP = 9;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LN-1:0]    in_lane_valid, out_lane_valid;
    logic [LN*NI-1:0] instruction_in, instruction_out;
    logic [LN*NP-1:0] pc_in, pc_out;
    logic [1:0]       occupancy;
    logic [15:0]      bp_cycles;

    always #5 clk = ~clk;

    pipe_skid_stage #(.N_INSTR(NI), .N_PC(NP), .LANES(LN)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_lane_valid   (in_lane_valid),
        .instruction_in  (instruction_in),
        .pc_in           (pc_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_lane_valid  (out_lane_valid),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .occupancy       (occupancy),
        .bp_cycles       (bp_cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: the stage is a FIFO of depth 2 whose head is what the output shows.
    typedef struct {
        logic [1:0]  m;
        logic [31:0] i;
        logic [17:0] p;
    } beat_t;

    beat_t       q[$];
    bit          m_rdy;
    int          m_bp;
    logic [31:0] m_li;
    logic [17:0] m_lp;

    task automatic model_reset();
        q.delete();
        m_rdy = 1'b0;
        m_bp  = 0;
        m_li  = '0;
        m_lp  = '0;
    endtask

    task automatic drive_edge(input bit fl, input bit iv, input logic [1:0] lv,
                              input logic [31:0] ins, input logic [17:0] pc, input bit ordy);
        bit    acc, pop, bpi;
        beat_t b;
        flush          = fl;
        in_valid       = iv;
        in_lane_valid  = lv;
        instruction_in = ins;
        pc_in          = pc;
        out_ready      = ordy;
        acc = iv && m_rdy;
        pop = (q.size() > 0) && ordy;
        bpi = (q.size() > 0) && !ordy;
        @(posedge clk);
        if (bpi && m_bp < 65535) m_bp++;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && lv != 2'b00) begin
                b.m = lv; b.i = ins; b.p = pc;
                q.push_back(b);
            end
        end
        m_rdy = (q.size() < 2);
        if (q.size() > 0) begin
            m_li = q[0].i;
            m_lp = q[0].p;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        bit ne;
        ne = (q.size() > 0);
        chk({tag, ".out_valid"}, out_valid, ne);
        chk({tag, ".occupancy"}, occupancy, q.size());
        chk({tag, ".in_ready"}, in_ready, m_rdy);
        chk({tag, ".bp_cycles"}, bp_cycles, m_bp);
        chk({tag, ".lane_valid"}, out_lane_valid, ne ? q[0].m : 2'b00);
        chk({tag, ".instr"}, instruction_out, ne ? q[0].i : m_li);
        chk({tag, ".pc"}, pc_out, ne ? q[0].p : m_lp);
    endtask

    typedef struct {
        bit          fl, iv;
        logic [1:0]  lv;
        logic [31:0] ins;
        logic [17:0] pc;
        bit          ordy;
        bit          ov;
        logic [1:0]  occ;
        bit          ird;
        logic [1:0]  olv;
        logic [31:0] iout;
        logic [17:0] pout;
        logic [15:0] bp;
    } vec_t;

    vec_t tv[13];

    initial begin
        // single beat, then backpressure ordering, then lane-mask cases
        tv[0]  = '{0,1,2'b01,32'h0000A5A5,18'h00012,1, 1,2'd1,1,2'b01,32'h0000A5A5,18'h00012,16'd0};
        tv[1]  = '{0,0,2'b00,32'h00000000,18'h00000,1, 0,2'd0,1,2'b00,32'h0000A5A5,18'h00012,16'd0};
        tv[2]  = '{0,1,2'b01,32'h00001111,18'h00001,0, 1,2'd1,1,2'b01,32'h00001111,18'h00001,16'd0};
        tv[3]  = '{0,1,2'b01,32'h00002222,18'h00002,0, 1,2'd2,0,2'b01,32'h00001111,18'h00001,16'd1};
        tv[4]  = '{0,1,2'b01,32'h00003333,18'h00003,0, 1,2'd2,0,2'b01,32'h00001111,18'h00001,16'd2};
        tv[5]  = '{0,1,2'b01,32'h00003333,18'h00003,1, 1,2'd1,1,2'b01,32'h00002222,18'h00002,16'd2};
        tv[6]  = '{0,1,2'b01,32'h00003333,18'h00003,1, 1,2'd1,1,2'b01,32'h00003333,18'h00003,16'd2};
        tv[7]  = '{0,0,2'b00,32'h00000000,18'h00000,1, 0,2'd0,1,2'b00,32'h00003333,18'h00003,16'd2};
        tv[8]  = '{0,1,2'b00,32'h00007777,18'h00007,1, 0,2'd0,1,2'b00,32'h00003333,18'h00003,16'd2};
        tv[9]  = '{0,1,2'b10,32'hBEEF0000,18'h0AA00,0, 1,2'd1,1,2'b10,32'hBEEF0000,18'h0AA00,16'd2};
        tv[10] = '{0,0,2'b00,32'h00000000,18'h00000,0, 1,2'd1,1,2'b10,32'hBEEF0000,18'h0AA00,16'd3};
        tv[11] = '{0,1,2'b00,32'h99999999,18'h00009,0, 1,2'd1,1,2'b10,32'hBEEF0000,18'h0AA00,16'd4};
        tv[12] = '{0,0,2'b00,32'h00000000,18'h00000,1, 0,2'd0,1,2'b00,32'hBEEF0000,18'h0AA00,16'd4};

        reset = 1'b1; flush = 0; in_valid = 0; in_lane_valid = '0;
        instruction_in = '0; pc_in = '0; out_ready = 1'b1;
        model_reset();
        #3;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.occupancy", occupancy, 0);
        chk("rst.bp_cycles", bp_cycles, 0);
        #9 reset = 1'b0;
        drive_edge(0, 0, 2'b00, 0, 0, 1);
        check_model("post_rst");

        for (int k = 0; k < 13; k++) begin
            string s;
            s = $sformatf("vec%0d", k);
            drive_edge(tv[k].fl, tv[k].iv, tv[k].lv, tv[k].ins, tv[k].pc, tv[k].ordy);
            chk({s, ".out_valid"}, out_valid, tv[k].ov);
            chk({s, ".occupancy"}, occupancy, tv[k].occ);
            chk({s, ".in_ready"}, in_ready, tv[k].ird);
            chk({s, ".lane_valid"}, out_lane_valid, tv[k].olv);
            chk({s, ".instr"}, instruction_out, tv[k].iout);
            chk({s, ".pc"}, pc_out, tv[k].pout);
            chk({s, ".bp"}, bp_cycles, tv[k].bp);
        end

        // flush in FULL with a beat offered in the same cycle
        drive_edge(0, 1, 2'b01, 32'h00000101, 18'h00011, 0);
        drive_edge(0, 1, 2'b01, 32'h00000202, 18'h00022, 0);
        chk("fl.full", occupancy, 2);
        drive_edge(1, 1, 2'b01, 32'h0000DEAD, 18'h000DD, 0);
        chk("fl.occ", occupancy, 0);
        chk("fl.out_valid", out_valid, 0);
        chk("fl.lane_valid", out_lane_valid, 0);
        for (int k = 0; k < 3; k++) begin
            drive_edge(0, 0, 2'b00, 0, 0, 1);
            check_model("fl.after");
            chk("fl.no_dead", instruction_out[15:0] == 16'hDEAD, 0);
        end

        // asynchronous reset between edges while FULL
        drive_edge(0, 1, 2'b11, 32'h44443333, 18'h00101, 0);
        drive_edge(0, 1, 2'b01, 32'h00005555, 18'h00102, 0);
        chk("ar.full", occupancy, 2);
        in_valid = 0; out_ready = 0;
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("ar.out_valid", out_valid, 0);
        chk("ar.occ", occupancy, 0);
        chk("ar.in_ready", in_ready, 0);
        chk("ar.lane_valid", out_lane_valid, 0);
        chk("ar.instr", instruction_out, 0);
        chk("ar.bp", bp_cycles, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        chk("ar.rdy_low", in_ready, 0);
        drive_edge(0, 0, 2'b00, 0, 0, 1);
        chk("ar.rdy_high", in_ready, 1);
        check_model("ar.post");

        // continuous streaming
        for (int k = 0; k < 100; k++) begin
            drive_edge(0, 1, 2'b01, 32'h100 + k, 18'(k), 1);
            chk("st.occ", occupancy, 1);
            chk("st.instr", instruction_out, 32'h100 + k);
        end
        chk("st.bp", bp_cycles, 0);
        check_model("st.end");

        // random traffic against the FIFO model
        for (int k = 0; k < 600; k++) begin
            drive_edge($urandom_range(15) == 0, $urandom_range(3) != 0,
                       2'($urandom), $urandom, 18'($urandom), $urandom_range(2) != 0);
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
